// File: rtl/cpu_ctrl_fsm_pkg.sv
// rtl/cpu_ctrl_fsm_pkg.sv - shared state and op-class encodings for the instruction sequencer
// Purpose: single source of truth for the sequencer state encoding (also exported on state_o
//          for trace) and the decoder op_class codes.
// Ports:   none (package).
package cpu_ctrl_fsm_pkg;

  localparam int CTRL_STATE_W = 4;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_INIT       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MEM        = 4'd5,
    S_WB         = 4'd6,
    S_NEXT_INS   = 4'd7,
    S_HALT       = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_LOAD   = 2'd1,
    OPC_STORE  = 2'd2,
    OPC_BRANCH = 2'd3
  } op_class_t;

endpackage

// File: rtl/cpu_ctrl_fsm_wait_counter.sv
// rtl/cpu_ctrl_fsm_wait_counter.sv - loadable saturating down-counter with last-cycle flag
// Purpose: module ctrl_wait_counter. Holds load_val while load=1; each cycle with dec=1 counts
//          down, stopping at 0. done is high while the count is exactly 1, i.e. during the last
//          counted cycle. A load value of 0 therefore never raises done.
// Ports:
//   clk       in  1  clock
//   reset_n   in  1  synchronous active-low reset (count <= 0)
//   load      in  1  reload count from load_val (has priority over dec)
//   dec       in  1  count down by one, saturating at 0
//   load_val  in  W  reload value
//   done      out 1  count == 1
module ctrl_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
// Purpose: drives datapath write enables and the data-memory port from a Moore FSM.
//          Optional debug halt is compiled in with the macro CTRL_DEBUG_HALT_EN.
// Parameters: FETCH_WAIT (1..15), MEM_WAIT_MAX (0..255, 0 = no timeout), STATE_W.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   op_class[1:0]         decoded class, captured in S_DECODE
//   mem_ready             data memory done (looked at only in S_MEM)
//   halt_req              debug halt request (CTRL_DEBUG_HALT_EN only)
//   fd_wren, rf_wren,
//   pc_wren               datapath write enables
//   mem_req, mem_we       data-memory request / write qualifier
//   mem_err               one-cycle pulse after a memory timeout
//   halted                core halted
//   state_o[STATE_W-1:0]  current state for trace
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int FETCH_WAIT   = 1,
  parameter int MEM_WAIT_MAX = 15,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         op_class,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               fd_wren,
  output logic               rf_wren,
  output logic               mem_req,
  output logic               mem_we,
  output logic               pc_wren,
  output logic               mem_err,
  output logic               halted,
  output logic [STATE_W-1:0] state_o
);

  state_t    state, state_next;
  op_class_t op_q;
  logic      fetch_done;
  logic      mem_limit;
  logic      mem_err_next;

  // Each counter sits loaded while outside its state, so it is fresh on entry.
  ctrl_wait_counter #(.W(4)) u_fetch_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state != S_FETCH_WAIT),
    .dec      (state == S_FETCH_WAIT),
    .load_val (4'(FETCH_WAIT)),
    .done     (fetch_done)
  );

  // Counts down the remaining not-ready budget; MEM_WAIT_MAX=0 never reaches 1.
  ctrl_wait_counter #(.W(8)) u_mem_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state != S_MEM),
    .dec      ((state == S_MEM) && !mem_ready),
    .load_val (8'(MEM_WAIT_MAX)),
    .done     (mem_limit)
  );

  // op_class is latched so mem_we and routing depend only on registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_INIT;
      op_q    <= OPC_ALU;
      mem_err <= 1'b0;
    end else begin
      state   <= state_next;
      mem_err <= mem_err_next;
      if (state == S_DECODE) begin
        op_q <= op_class_t'(op_class);
      end
    end
  end

  always_comb begin
    state_next   = state;
    mem_err_next = 1'b0;
    case (state)
      S_INIT:       state_next = S_FETCH;
      S_FETCH:      state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: if (fetch_done) state_next = S_DECODE;
      S_DECODE:     state_next = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OPC_ALU:             state_next = S_WB;
          OPC_LOAD, OPC_STORE: state_next = S_MEM;
          default:             state_next = S_NEXT_INS;
        endcase
      end
      S_MEM: begin
        // A ready arriving on the limit cycle completes normally.
        if (mem_ready) begin
          state_next = (op_q == OPC_LOAD) ? S_WB : S_NEXT_INS;
        end else if (mem_limit) begin
          state_next   = S_NEXT_INS;
          mem_err_next = 1'b1;
        end
      end
      S_WB:         state_next = S_NEXT_INS;
`ifdef CTRL_DEBUG_HALT_EN
      S_NEXT_INS:   state_next = halt_req ? S_HALT : S_FETCH;
      S_HALT:       if (!halt_req) state_next = S_FETCH;
`else
      S_NEXT_INS:   state_next = S_FETCH;
`endif
      default:      state_next = S_INIT;
    endcase
  end

  assign fd_wren = (state == S_FETCH_WAIT) && fetch_done;
  assign rf_wren = (state == S_WB);
  assign mem_req = (state == S_MEM);
  assign mem_we  = (state == S_MEM) && (op_q == OPC_STORE);
  assign pc_wren = (state == S_NEXT_INS);
  assign state_o = STATE_W'(state);

`ifdef CTRL_DEBUG_HALT_EN
  assign halted = (state == S_HALT);
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] op_class = 2'd0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;

  logic       fd_a, rf_a, mreq_a, we_a, pc_a, err_a, halted_a;
  logic [3:0] state_a;
  logic       fd_b;
  logic       unused_rf_b, unused_mreq_b, unused_we_b, unused_pc_b, unused_err_b, unused_halted_b;
  logic [3:0] unused_state_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.FETCH_WAIT(1), .MEM_WAIT_MAX(15), .STATE_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .op_class(op_class), .mem_ready(mem_ready),
    .halt_req(halt_req), .fd_wren(fd_a), .rf_wren(rf_a), .mem_req(mreq_a),
    .mem_we(we_a), .pc_wren(pc_a), .mem_err(err_a), .halted(halted_a), .state_o(state_a)
  );

  cpu_ctrl_fsm #(.FETCH_WAIT(3), .MEM_WAIT_MAX(15), .STATE_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .op_class(2'd0), .mem_ready(1'b0),
    .halt_req(1'b0), .fd_wren(fd_b), .rf_wren(unused_rf_b), .mem_req(unused_mreq_b),
    .mem_we(unused_we_b), .pc_wren(unused_pc_b), .mem_err(unused_err_b),
    .halted(unused_halted_b), .state_o(unused_state_b)
  );

  typedef struct {
    logic [1:0] op;
    int         ready_after;
    int         len;
    int         fd_cyc;
    int         rf_cyc;
    int         memreq_n;
    int         we;
    int         err_n;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Precondition: the next falling edge samples S_FETCH. Returns at the pc_wren cycle.
  task automatic run_instr(input logic [1:0] op, input int ra,
                           output int len, output int fd, output int rf,
                           output int mreq, output int we, output int err, output int fdb);
    int  c;
    bit  done;
    c = 0; done = 0;
    len = 0; fd = 0; rf = 0; mreq = 0; we = 0; err = 0; fdb = 0;
    op_class  = op;
    mem_ready = 1'b0;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      if (c == 1) check("start_state", int'(state_a), int'(S_FETCH));
      check("onehot_enables", int'($onehot0({fd_a, rf_a, pc_a, mreq_a})), 1);
      check("we_without_req", int'(we_a & ~mreq_a), 0);
      check("halted_in_instr", int'(halted_a), 0);
      if (fd_a && fd == 0) fd = c;
      if (rf_a && rf == 0) rf = c;
      if (mreq_a) mreq++;
      if (we_a) we = 1;
      if (err_a) err++;
      if (fd_b && fdb == 0) fdb = c;
      mem_ready = mreq_a && (mreq > ra);
      if (pc_a) begin
        len  = c;
        done = 1;
      end
    end
    mem_ready = 1'b0;
    if (!done) check("instr_timeout", 0, 1);
  endtask

  initial begin
    int len, fd, rf, mreq, we, err, fdb;
    int ra, mcyc, e_len, e_rf, e_err, e_mreq;
    logic [1:0] op;

    //          op          ra   len fd rf mreq we err
    vecs[0] = '{OPC_ALU,    0,   6,  2, 5, 0,   0, 0};
    vecs[1] = '{OPC_LOAD,   0,   7,  2, 6, 1,   0, 0};
    vecs[2] = '{OPC_STORE,  0,   6,  2, 0, 1,   1, 0};
    vecs[3] = '{OPC_BRANCH, 0,   5,  2, 0, 0,   0, 0};
    vecs[4] = '{OPC_LOAD,   4,   11, 2, 10, 5,  0, 0};
    vecs[5] = '{OPC_STORE,  255, 20, 2, 0, 15,  1, 1};
    vecs[6] = '{OPC_LOAD,   14,  21, 2, 20, 15, 0, 0};
    vecs[7] = '{OPC_LOAD,   255, 20, 2, 0, 15,  0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", int'(state_a), int'(S_INIT));
    check("reset_outputs", int'({fd_a, rf_a, mreq_a, we_a, pc_a, err_a, halted_a}), 0);
    reset_n = 1'b1;

    // FETCH_WAIT=3 instance runs ALU alongside the first instruction.
    run_instr(OPC_ALU, 0, len, fd, rf, mreq, we, err, fdb);
    check("fw3_fd_cycle", fdb, 4);
    check("first_alu_len", len, 6);

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].op, vecs[i].ready_after, len, fd, rf, mreq, we, err, fdb);
      check($sformatf("v%0d_len", i), len, vecs[i].len);
      check($sformatf("v%0d_fd", i), fd, vecs[i].fd_cyc);
      check($sformatf("v%0d_rf", i), rf, vecs[i].rf_cyc);
      check($sformatf("v%0d_memreq", i), mreq, vecs[i].memreq_n);
      check($sformatf("v%0d_we", i), we, vecs[i].we);
      check($sformatf("v%0d_err", i), err, vecs[i].err_n);
    end

    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = int'($urandom_range(0, 3));
      mcyc = (ra >= 15) ? 15 : ra + 1;
      e_err = 0; e_rf = 0; e_mreq = 0;
      case (op)
        OPC_ALU:   begin e_len = 6; e_rf = 5; end
        OPC_LOAD:  begin
          e_mreq = mcyc;
          if (ra >= 15) begin e_len = 4 + mcyc + 1; e_err = 1; end
          else begin e_len = 4 + mcyc + 2; e_rf = 4 + mcyc + 1; end
        end
        OPC_STORE: begin e_mreq = mcyc; e_len = 4 + mcyc + 1; e_err = (ra >= 15) ? 1 : 0; end
        default:   e_len = 5;
      endcase
      run_instr(op, ra, len, fd, rf, mreq, we, err, fdb);
      check($sformatf("rnd%0d_len", i), len, e_len);
      check($sformatf("rnd%0d_rf", i), rf, e_rf);
      check($sformatf("rnd%0d_memreq", i), mreq, e_mreq);
      check($sformatf("rnd%0d_err", i), err, e_err);
    end

    // Reset in the middle of a stalled load.
    op_class  = OPC_LOAD;
    mem_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_mem_req", int'(mreq_a), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midmem_reset_state", int'(state_a), int'(S_INIT));
    check("midmem_reset_outputs", int'({fd_a, rf_a, mreq_a, we_a, pc_a, err_a, halted_a}), 0);
    repeat (2) @(negedge clk);
    check("reset_hold_state", int'(state_a), int'(S_INIT));
    reset_n = 1'b1;
    run_instr(OPC_BRANCH, 0, len, fd, rf, mreq, we, err, fdb);
    check("post_reset_branch_len", len, 5);

`ifdef CTRL_DEBUG_HALT_EN
    halt_req = 1'b1;
    run_instr(OPC_ALU, 0, len, fd, rf, mreq, we, err, fdb);
    check("halt_instr_len", len, 6);
    @(negedge clk);
    check("halt_state", int'(state_a), int'(S_HALT));
    check("halt_flag", int'(halted_a), 1);
    check("halt_enables", int'({fd_a, rf_a, mreq_a, pc_a}), 0);
    @(negedge clk);
    check("halt_hold_state", int'(state_a), int'(S_HALT));
    halt_req = 1'b0;
    run_instr(OPC_ALU, 0, len, fd, rf, mreq, we, err, fdb);
    check("after_halt_len", len, 6);
`else
    halt_req = 1'b1;
    run_instr(OPC_ALU, 0, len, fd, rf, mreq, we, err, fdb);
    check("ignored_halt_len", len, 6);
    halt_req = 1'b0;
    run_instr(OPC_BRANCH, 0, len, fd, rf, mreq, we, err, fdb);
    check("after_ignored_halt_len", len, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
